// File: rtl/barrett_red_scheduler.sv
// Issue scheduler for a shared, pipelined Barrett unit: round-robin arbitration of
// reduction and multiply-only requests, a structural-hazard guard, and drain-then-load reconfiguration.
module barrett_red_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        red_valid,
  output logic        red_ready,
  input  logic [59:0] red_a,
  input  logic        mul_valid,
  output logic        mul_ready,
  input  logic [29:0] mul_a1,
  input  logic [29:0] mul_a2,
  input  logic [29:0] mul_a3,
  input  logic [29:0] mul_a4,
  input  logic [30:0] mul_b1,
  input  logic [30:0] mul_b2,
  input  logic [30:0] mul_b3,
  input  logic [30:0] mul_b4,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [29:0] cfg_prime,
  input  logic [30:0] cfg_const,
  output logic [59:0] u_a,
  output logic        u_only_multiply,
  output logic [29:0] u_ina1,
  output logic [29:0] u_ina2,
  output logic [29:0] u_ina3,
  output logic [29:0] u_ina4,
  output logic [30:0] u_inb1,
  output logic [30:0] u_inb2,
  output logic [30:0] u_inb3,
  output logic [30:0] u_inb4,
  output logic [29:0] u_prime,
  output logic [30:0] u_barrett_const,
  input  logic [29:0] u_b,
  input  logic [59:0] u_out1,
  input  logic [59:0] u_out2,
  input  logic [59:0] u_out3,
  input  logic [59:0] u_out4,
  output logic        red_out_valid,
  output logic [29:0] red_out,
  output logic        mul_out_valid,
  output logic [59:0] mul_out1,
  output logic [59:0] mul_out2,
  output logic [59:0] mul_out3,
  output logic [59:0] mul_out4,
  output logic        busy
);

  localparam int RED_LAT   = 10;
  localparam int MUL_LAT   = 4;
  localparam int HAZ_DEPTH = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic                 prio_red_reg;
  logic                 prio_red_next;
  logic [HAZ_DEPTH-1:0] red_hist_reg;
  logic [RED_LAT-1:0]   red_tag_reg;
  logic [MUL_LAT-1:0]   mul_tag_reg;

  logic issue_en;
  logic red_elig;
  logic mul_elig;
  logic grant_red;
  logic grant_mul;
  logic drained;

  logic [29:0] mul_a_arr   [4];
  logic [30:0] mul_b_arr   [4];
  logic [59:0] u_out_arr   [4];
  logic [29:0] ina_arr     [4];
  logic [30:0] inb_arr     [4];
  logic [59:0] mul_out_arr [4];

  assign mul_a_arr[0] = mul_a1;
  assign mul_a_arr[1] = mul_a2;
  assign mul_a_arr[2] = mul_a3;
  assign mul_a_arr[3] = mul_a4;
  assign mul_b_arr[0] = mul_b1;
  assign mul_b_arr[1] = mul_b2;
  assign mul_b_arr[2] = mul_b3;
  assign mul_b_arr[3] = mul_b4;
  assign u_out_arr[0] = u_out1;
  assign u_out_arr[1] = u_out2;
  assign u_out_arr[2] = u_out3;
  assign u_out_arr[3] = u_out4;

  // The oldest history bit marks a reduction whose quotient step now occupies multiplier 3.
  always_comb begin
    issue_en      = (state_reg == RUN) && !cfg_valid && !rst;
    red_elig      = issue_en && red_valid;
    mul_elig      = issue_en && mul_valid && !red_hist_reg[HAZ_DEPTH-1];
    grant_red     = red_elig && (!mul_elig || prio_red_reg);
    grant_mul     = mul_elig && !grant_red;
    prio_red_next = prio_red_reg;
    if (grant_red) begin
      prio_red_next = 1'b0;
    end else if (grant_mul) begin
      prio_red_next = 1'b1;
    end
  end

  // Every in-flight result retires by the end of this cycle, so LOAD sees empty pipes.
  assign drained = (red_tag_reg[RED_LAT-2:0] == '0) && (mul_tag_reg[MUL_LAT-2:0] == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (cfg_valid) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!cfg_valid) begin
          state_next = RUN;
        end else if (drained) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign red_ready = grant_red;
  assign mul_ready = grant_mul;
  assign cfg_ready = (state_reg == LOAD) && !rst;
  assign busy      = (|red_tag_reg) || (|mul_tag_reg) || (state_reg != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      prio_red_reg <= 1'b1;
      red_hist_reg <= '0;
      red_tag_reg  <= '0;
      mul_tag_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      prio_red_reg <= prio_red_next;
      red_hist_reg <= {red_hist_reg[HAZ_DEPTH-2:0], grant_red};
      red_tag_reg  <= {red_tag_reg[RED_LAT-2:0], grant_red};
      mul_tag_reg  <= {mul_tag_reg[MUL_LAT-2:0], grant_mul};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_a             <= '0;
      u_only_multiply <= 1'b0;
    end else begin
      u_a             <= grant_red ? red_a : '0;
      u_only_multiply <= grant_mul;
    end
  end

  // Modulus and constant move only in LOAD, which is reached with nothing in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_prime         <= '0;
      u_barrett_const <= '0;
    end else if (cfg_ready && cfg_valid) begin
      u_prime         <= cfg_prime;
      u_barrett_const <= cfg_const;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [29:0] ina_reg;
      logic [30:0] inb_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ina_reg <= '0;
          inb_reg <= '0;
        end else if (grant_mul) begin
          ina_reg <= mul_a_arr[gi];
          inb_reg <= mul_b_arr[gi];
        end else begin
          ina_reg <= '0;
          inb_reg <= '0;
        end
      end

      assign ina_arr[gi]     = ina_reg;
      assign inb_arr[gi]     = inb_reg;
      assign mul_out_arr[gi] = mul_tag_reg[MUL_LAT-1] ? u_out_arr[gi] : '0;
    end
  endgenerate

  assign u_ina1 = ina_arr[0];
  assign u_ina2 = ina_arr[1];
  assign u_ina3 = ina_arr[2];
  assign u_ina4 = ina_arr[3];
  assign u_inb1 = inb_arr[0];
  assign u_inb2 = inb_arr[1];
  assign u_inb3 = inb_arr[2];
  assign u_inb4 = inb_arr[3];

  assign red_out_valid = red_tag_reg[RED_LAT-1];
  assign red_out       = red_tag_reg[RED_LAT-1] ? u_b : '0;
  assign mul_out_valid = mul_tag_reg[MUL_LAT-1];
  assign mul_out1      = mul_out_arr[0];
  assign mul_out2      = mul_out_arr[1];
  assign mul_out3      = mul_out_arr[2];
  assign mul_out4      = mul_out_arr[3];

endmodule

// File: tb/tb_barrett_red_scheduler.sv
// Bench for barrett_red_scheduler: behavioural Barrett unit on the u_* side and a
// cycle-numbered scoreboard of grants, results, configuration and busy.
module tb_barrett_red_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        red_valid = 1'b0;
  logic        red_ready;
  logic [59:0] red_a = '0;
  logic        mul_valid = 1'b0;
  logic        mul_ready;
  logic [29:0] mul_a1 = '0, mul_a2 = '0, mul_a3 = '0, mul_a4 = '0;
  logic [30:0] mul_b1 = '0, mul_b2 = '0, mul_b3 = '0, mul_b4 = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [29:0] cfg_prime = '0;
  logic [30:0] cfg_const = '0;
  logic [59:0] u_a;
  logic        u_only_multiply;
  logic [29:0] u_ina1, u_ina2, u_ina3, u_ina4;
  logic [30:0] u_inb1, u_inb2, u_inb3, u_inb4;
  logic [29:0] u_prime;
  logic [30:0] u_barrett_const;
  logic [29:0] u_b;
  logic [59:0] u_out1, u_out2, u_out3, u_out4;
  logic        red_out_valid;
  logic [29:0] red_out;
  logic        mul_out_valid;
  logic [59:0] mul_out1, mul_out2, mul_out3, mul_out4;
  logic        busy;

  always #5 clk = ~clk;

  barrett_red_scheduler dut (
    .clk(clk), .rst(rst),
    .red_valid(red_valid), .red_ready(red_ready), .red_a(red_a),
    .mul_valid(mul_valid), .mul_ready(mul_ready),
    .mul_a1(mul_a1), .mul_a2(mul_a2), .mul_a3(mul_a3), .mul_a4(mul_a4),
    .mul_b1(mul_b1), .mul_b2(mul_b2), .mul_b3(mul_b3), .mul_b4(mul_b4),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_prime(cfg_prime), .cfg_const(cfg_const),
    .u_a(u_a), .u_only_multiply(u_only_multiply),
    .u_ina1(u_ina1), .u_ina2(u_ina2), .u_ina3(u_ina3), .u_ina4(u_ina4),
    .u_inb1(u_inb1), .u_inb2(u_inb2), .u_inb3(u_inb3), .u_inb4(u_inb4),
    .u_prime(u_prime), .u_barrett_const(u_barrett_const),
    .u_b(u_b), .u_out1(u_out1), .u_out2(u_out2), .u_out3(u_out3), .u_out4(u_out4),
    .red_out_valid(red_out_valid), .red_out(red_out),
    .mul_out_valid(mul_out_valid),
    .mul_out1(mul_out1), .mul_out2(mul_out2), .mul_out3(mul_out3), .mul_out4(mul_out4),
    .busy(busy)
  );

  // Behavioural Barrett unit: the 31-bit constant carries an implicit 2^31 bit,
  // since 2^61/p lies in (2^31, 2^32) for any 30-bit prime above 2^29.
  function automatic logic [29:0] barrett(input logic [59:0] a, input logic [29:0] p,
                                          input logic [30:0] c);
    logic [127:0] prod;
    logic [63:0]  q;
    logic [63:0]  r;
    if (p == '0) return '0;
    prod = 128'(a) * (128'(c) + (128'd1 << 31));
    q    = 64'(prod >> 61);
    r    = 64'(a) - q * 64'(p);
    for (int i = 0; i < 4; i++) if (r >= 64'(p)) r = r - 64'(p);
    return r[29:0];
  endfunction

  logic [29:0]      ub_pipe [9];
  logic [3:0][59:0] uo_pipe [3];
  initial begin
    for (int k = 0; k < 9; k++) ub_pipe[k] = '0;
    for (int k = 0; k < 3; k++) uo_pipe[k] = '0;
  end
  always @(posedge clk) begin
    ub_pipe[0] <= u_only_multiply ? 30'd0 : barrett(u_a, u_prime, u_barrett_const);
    for (int k = 1; k < 9; k++) ub_pipe[k] <= ub_pipe[k-1];
    uo_pipe[0] <= u_only_multiply ?
                  {60'(64'(u_ina4) * 64'(u_inb4)), 60'(64'(u_ina3) * 64'(u_inb3)),
                   60'(64'(u_ina2) * 64'(u_inb2)), 60'(64'(u_ina1) * 64'(u_inb1))} : '0;
    uo_pipe[1] <= uo_pipe[0];
    uo_pipe[2] <= uo_pipe[1];
  end
  assign u_b    = ub_pipe[8];
  assign u_out1 = uo_pipe[2][0];
  assign u_out2 = uo_pipe[2][1];
  assign u_out3 = uo_pipe[2][2];
  assign u_out4 = uo_pipe[2][3];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model, indexed by absolute cycle number.
  typedef struct { int due; logic [29:0] v; } red_exp_t;
  typedef struct { int due; logic [3:0][59:0] v; } mul_exp_t;

  red_exp_t         red_q [$];
  mul_exp_t         mul_q [$];
  int               cyc = 0;
  int               mode = 0;          // 0 issuing, 1 waiting for empty pipes, 2 loading
  bit               prio_red = 1'b1;
  bit               red_hist [64];
  logic [29:0]      prime_m = '0;
  logic [30:0]      const_m = '0;
  logic             exp_uo = 1'b0;
  logic [59:0]      exp_ua = '0;
  logic [3:0][29:0] exp_ina = '0;
  logic [3:0][30:0] exp_inb = '0;
  bit               loaded_now = 1'b0;

  task automatic model_reset();
    red_q.delete();
    mul_q.delete();
    mode = 0;
    prio_red = 1'b1;
    for (int k = 0; k < 64; k++) red_hist[k] = 1'b0;
    prime_m = '0;
    const_m = '0;
    exp_uo = 1'b0;
    exp_ua = '0;
    exp_ina = '0;
    exp_inb = '0;
  endtask

  task automatic step();
    logic [3:0][29:0] ma;
    logic [3:0][30:0] mb;
    logic [3:0][59:0] prods;
    logic [3:0][59:0] exp_mo;
    logic [29:0]      exp_ro;
    bit hz, issue, r_el, m_el, g_r, g_m, exp_rv, exp_mv, busy_e;
    #1;
    ma = {mul_a4, mul_a3, mul_a2, mul_a1};
    mb = {mul_b4, mul_b3, mul_b2, mul_b1};
    for (int k = 0; k < 4; k++) prods[k] = 60'(64'(ma[k]) * 64'(mb[k]));
    hz    = red_hist[(cyc - 4) & 63];
    issue = (mode == 0) && !cfg_valid;
    r_el  = issue && red_valid;
    m_el  = issue && mul_valid && !hz;
    g_r   = r_el && (!m_el || prio_red);
    g_m   = m_el && !g_r;
    busy_e = (red_q.size() != 0) || (mul_q.size() != 0) || (mode != 0);
    exp_rv = 1'b0; exp_ro = '0; exp_mv = 1'b0; exp_mo = '0;
    if (red_q.size() != 0 && red_q[0].due == cyc) begin
      exp_rv = 1'b1; exp_ro = red_q[0].v; void'(red_q.pop_front());
    end
    if (mul_q.size() != 0 && mul_q[0].due == cyc) begin
      exp_mv = 1'b1; exp_mo = mul_q[0].v; void'(mul_q.pop_front());
    end
    check_eq("red_ready", 64'(red_ready), 64'(g_r));
    check_eq("mul_ready", 64'(mul_ready), 64'(g_m));
    check_eq("cfg_ready", 64'(cfg_ready), 64'(mode == 2));
    check_eq("busy", 64'(busy), 64'(busy_e));
    check_eq("red_out_valid", 64'(red_out_valid), 64'(exp_rv));
    check_eq("red_out", 64'(red_out), 64'(exp_ro));
    check_eq("mul_out_valid", 64'(mul_out_valid), 64'(exp_mv));
    check_eq("mul_out1", 64'(mul_out1), 64'(exp_mo[0]));
    check_eq("mul_out2", 64'(mul_out2), 64'(exp_mo[1]));
    check_eq("mul_out3", 64'(mul_out3), 64'(exp_mo[2]));
    check_eq("mul_out4", 64'(mul_out4), 64'(exp_mo[3]));
    check_eq("u_only_multiply", 64'(u_only_multiply), 64'(exp_uo));
    check_eq("u_a", 64'(u_a), 64'(exp_ua));
    check_eq("u_ina1", 64'(u_ina1), 64'(exp_ina[0]));
    check_eq("u_inb1", 64'(u_inb1), 64'(exp_inb[0]));
    check_eq("u_ina4", 64'(u_ina4), 64'(exp_ina[3]));
    check_eq("u_inb4", 64'(u_inb4), 64'(exp_inb[3]));
    check_eq("u_prime", 64'(u_prime), 64'(prime_m));
    check_eq("u_barrett_const", 64'(u_barrett_const), 64'(const_m));
    if (g_r) $display("[%0d] red grant a=%h", cyc, red_a);
    if (g_m) $display("[%0d] mul grant a1=%h b1=%h", cyc, mul_a1, mul_b1);
    @(posedge clk);
    loaded_now = 1'b0;
    red_hist[cyc & 63] = g_r;
    exp_uo = g_m;
    exp_ua = g_r ? red_a : '0;
    exp_ina = g_m ? ma : '0;
    exp_inb = g_m ? mb : '0;
    if (g_r) begin
      red_q.push_back('{due: cyc + 10,
                        v: (prime_m == '0) ? 30'd0 : 30'(64'(red_a) % 64'(prime_m))});
      prio_red = 1'b0;
    end else if (g_m) begin
      mul_q.push_back('{due: cyc + 4, v: prods});
      prio_red = 1'b1;
    end
    case (mode)
      0: if (cfg_valid) mode = 1;
      1: begin
        if (!cfg_valid) mode = 0;
        else if (red_q.size() == 0 && mul_q.size() == 0) mode = 2;
      end
      default: begin
        if (cfg_valid) begin
          prime_m = cfg_prime;
          const_m = cfg_const;
          loaded_now = 1'b1;
        end
        mode = 0;
      end
    endcase
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_red_ready"}, 64'(red_ready), 64'd0);
    check_eq({tag, "_mul_ready"}, 64'(mul_ready), 64'd0);
    check_eq({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
    check_eq({tag, "_red_out_valid"}, 64'(red_out_valid), 64'd0);
    check_eq({tag, "_red_out"}, 64'(red_out), 64'd0);
    check_eq({tag, "_mul_out_valid"}, 64'(mul_out_valid), 64'd0);
    check_eq({tag, "_mul_out1"}, 64'(mul_out1), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_u_a"}, 64'(u_a), 64'd0);
    check_eq({tag, "_u_only_multiply"}, 64'(u_only_multiply), 64'd0);
    check_eq({tag, "_u_ina1"}, 64'(u_ina1), 64'd0);
    check_eq({tag, "_u_inb1"}, 64'(u_inb1), 64'd0);
    check_eq({tag, "_u_prime"}, 64'(u_prime), 64'd0);
    check_eq({tag, "_u_barrett_const"}, 64'(u_barrett_const), 64'd0);
  endtask

  // Called at a falling edge: raises rst mid-cycle, checks before any clock edge.
  task automatic async_reset();
    red_valid = 1'b1; mul_valid = 1'b1; cfg_valid = 1'b1;
    #3; rst = 1'b1; #1;
    check_all_zero("async_rst");
    @(negedge clk); #1;
    check_all_zero("held_rst");
    @(negedge clk);
    red_valid = 1'b0; mul_valid = 1'b0; cfg_valid = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic rand_ops();
    red_a  = {28'($urandom), $urandom};
    mul_a1 = 30'($urandom); mul_a2 = 30'($urandom); mul_a3 = 30'($urandom); mul_a4 = 30'($urandom);
    mul_b1 = 31'($urandom); mul_b2 = 31'($urandom); mul_b3 = 31'($urandom); mul_b4 = 31'($urandom);
  endtask

  task automatic do_config(input logic [29:0] p);
    bit done;
    done = 1'b0;
    cfg_prime = p;
    cfg_const = 31'((64'd1 << 61) / 64'(p));
    cfg_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      done = loaded_now;
    end
    cfg_valid = 1'b0;
    check_eq("cfg_prime_visible", 64'(u_prime), 64'(p));
  endtask

  initial begin
    model_reset();
    @(negedge clk); #1;
    check_all_zero("por");
    @(negedge clk);
    rst = 1'b0;

    do_config(30'h3FFFFFDD);

    // Directed reduction of 0x1_2345_6789.
    red_a = 60'h0_0000_0001_2345_6789;
    red_valid = 1'b1; step(); red_valid = 1'b0;
    repeat (11) step();

    // Directed multiply 3*5 with the other lanes zero.
    mul_a1 = 30'd3; mul_b1 = 31'd5;
    mul_a2 = '0; mul_a3 = '0; mul_a4 = '0; mul_b2 = '0; mul_b3 = '0; mul_b4 = '0;
    mul_valid = 1'b1; step(); mul_valid = 1'b0;
    repeat (5) step();

    // One reduction followed by a stream of multiplies exercises the hazard slot.
    rand_ops(); red_valid = 1'b1; step(); red_valid = 1'b0;
    mul_valid = 1'b1;
    repeat (7) begin rand_ops(); step(); end
    mul_valid = 1'b0;

    // Both requesters continuously valid.
    red_valid = 1'b1; mul_valid = 1'b1;
    repeat (60) begin rand_ops(); step(); end

    // Random valids.
    repeat (200) begin
      rand_ops();
      red_valid = 1'($urandom);
      mul_valid = 1'($urandom);
      step();
    end
    red_valid = 1'b0; mul_valid = 1'b0;
    repeat (12) step();

    // Reconfigure with three reductions in flight and both requesters pushing.
    red_valid = 1'b1;
    repeat (3) begin rand_ops(); step(); end
    mul_valid = 1'b1;
    do_config(30'h3FFFFFC7);
    red_valid = 1'b0; mul_valid = 1'b0;
    repeat (12) step();

    // Withdrawn configuration request leaves the prime unchanged.
    rand_ops(); red_valid = 1'b1; step(); red_valid = 1'b0;
    cfg_prime = 30'h2000_0011; cfg_const = 31'h7FFF_FFFF;
    cfg_valid = 1'b1; repeat (3) step(); cfg_valid = 1'b0;
    repeat (12) step();

    red_valid = 1'b1; mul_valid = 1'b1;
    repeat (40) begin rand_ops(); red_valid = 1'($urandom); step(); end
    red_valid = 1'b0; mul_valid = 1'b0;
    repeat (12) step();

    // Reset five cycles after a reduction grant.
    rand_ops(); red_valid = 1'b1; step(); red_valid = 1'b0;
    repeat (4) step();
    async_reset();
    repeat (15) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
